// File: rtl/seg_scan_if.sv
// Bundle of control, data and display signals between a host and the
// multiplexed 7-segment scan controller.
`timescale 1ns/1ps
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_en;
  logic [3:0]              bcd;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp_n;
  logic                    pending;
  logic                    frame_done;

  // Host side: supplies data and control, observes the display lines.
  modport master (
    output en, load, data_in, dp_in, lz_en,
    input  bcd, an, dp_n, pending, frame_done
  );

  // Controller side.
  modport slave (
    input  en, load, data_in, dp_in, lz_en,
    output bcd, an, dp_n, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One shared BCD decoder is fed digit by digit; anodes and decimal point
// are active low. New data is staged in a pending register and only
// committed at a frame wrap (or while idle) so a frame is never torn.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(REFRESH_DIV + 1);
  localparam int GW    = $clog2(GUARD_CYCLES + 2);
  localparam int GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GRD_LAST = GW'(GLAST);

  typedef enum logic [1:0] {OFF, DRIVE, GUARD} state_t;

  state_t                  state_reg, state_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [PW-1:0]           pre_reg, pre_next;
  logic [GW-1:0]           grd_reg, grd_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [3:0]              bcd_reg, bcd_next;
  logic                    dp_n_reg, dp_n_next;
  logic                    frame_done_reg;

  logic [4*NUM_DIGITS-1:0] disp_data_reg, pend_data_reg;
  logic [NUM_DIGITS-1:0]   disp_dp_reg, pend_dp_reg;
  logic                    pending_reg;

  logic                    wrap;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] eff_data;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   digit_zero;
  logic [NUM_DIGITS-1:0]   blank;
  logic [IW-1:0]           sel;
  logic                    show;
  logic                    light;

  // The wrap edge is the terminal count of the last digit while enabled.
  assign wrap   = bus.en && (state_reg == DRIVE) && (pre_reg == PRE_LAST) &&
                  (idx_reg == IDX_LAST);
  assign commit = wrap || ((state_reg == OFF) && pending_reg);

  // Digit values visible after this edge: the pending copy if it commits now.
  assign eff_data = commit ? pend_data_reg : disp_data_reg;
  assign eff_dp   = commit ? pend_dp_reg   : disp_dp_reg;

  // A digit counts as "empty" only if its value and its decimal point are 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (eff_data[4*gi +: 4] == 4'd0) && !eff_dp[gi];
    end
  endgenerate

  // Leading-zero mask: blank digit i>0 when it and everything above is empty.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & digit_zero[i];
      blank[i] = bus.lz_en & zero_run;
    end
  end

  // Scan FSM next state plus the registered display outputs.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pre_next   = pre_reg;
    grd_next   = grd_reg;
    an_next    = an_reg;
    bcd_next   = bcd_reg;
    dp_n_next  = dp_n_reg;
    sel        = idx_reg;
    show       = 1'b0;
    light      = 1'b0;
    if (!bus.en) begin
      state_next = OFF;
      idx_next   = '0;
      pre_next   = '0;
      grd_next   = '0;
      an_next    = '1;
      dp_n_next  = 1'b1;
    end else begin
      unique case (state_reg)
        OFF: begin
          state_next = DRIVE;
          idx_next   = '0;
          pre_next   = '0;
          sel        = '0;
          show       = 1'b1;
          light      = 1'b1;
        end
        DRIVE: begin
          if (pre_reg == PRE_LAST) begin
            pre_next = '0;
            sel      = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            idx_next = sel;
            show     = 1'b1;
            if (GUARD_CYCLES > 0) begin
              state_next = GUARD;
              grd_next   = '0;
              an_next    = '1;
            end else begin
              light = 1'b1;
            end
          end else begin
            pre_next = pre_reg + 1'b1;
          end
        end
        GUARD: begin
          if (grd_reg == GRD_LAST) begin
            state_next = DRIVE;
            pre_next   = '0;
            light      = 1'b1;
          end else begin
            grd_next = grd_reg + 1'b1;
          end
        end
        default: state_next = OFF;
      endcase
    end
    // bcd/dp_n move to the new digit together; anode only when it is lit.
    if (show) begin
      bcd_next  = eff_data[4*sel +: 4];
      dp_n_next = ~eff_dp[sel];
    end
    if (light) begin
      an_next      = '1;
      an_next[sel] = blank[sel];
    end
  end

  // FSM state, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= OFF;
      idx_reg        <= '0;
      pre_reg        <= '0;
      grd_reg        <= '0;
      an_reg         <= '1;
      bcd_reg        <= 4'd0;
      dp_n_reg       <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      pre_reg        <= pre_next;
      grd_reg        <= grd_next;
      an_reg         <= an_next;
      bcd_reg        <= bcd_next;
      dp_n_reg       <= dp_n_next;
      frame_done_reg <= wrap;
    end
  end

  // Pending/display registers; a load on a commit edge keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_reg <= '0;
      pend_dp_reg   <= '0;
      disp_data_reg <= '0;
      disp_dp_reg   <= '0;
      pending_reg   <= 1'b0;
    end else begin
      if (commit) begin
        disp_data_reg <= pend_data_reg;
        disp_dp_reg   <= pend_dp_reg;
      end
      if (bus.load) begin
        pend_data_reg <= bus.data_in;
        pend_dp_reg   <= bus.dp_in;
        pending_reg   <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign bus.an         = an_reg;
  assign bus.bcd        = bcd_reg;
  assign bus.dp_n       = dp_n_reg;
  assign bus.pending    = pending_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes the hand-computed
// outputs expected after each clock edge; the monitor pops and compares.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;

  typedef struct {
    int         tst;
    int         cyc;
    logic [3:0] an;
    logic [3:0] bcd;
    logic       dp_n;
    logic       pend;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tst    = 0;
  int   cyc_no = 0;

  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared comparison: {an, bcd, dp_n, pending, frame_done}.
  task automatic compare(input int t, input int c, input logic [10:0] got,
                         input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL t%0d c%0d an/bcd/dp_n/pend/fd got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b",
               t, c, got[10:7], got[6:3], got[2], got[1], got[0],
               want[10:7], want[6:3], want[2], want[1], want[0]);
    end
  endtask

  // Push the expectation for the next edge, then move past that edge.
  task automatic chk(input logic [3:0] a, input logic [3:0] b, input logic dn,
                     input logic p, input logic f);
    exp_t e;
    e.tst = tst; e.cyc = cyc_no; e.an = a; e.bcd = b;
    e.dp_n = dn; e.pend = p; e.fd = f;
    exp_q.push_back(e);
    cyc_no++;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic dn,
                       input logic p);
    repeat (RD) chk(a, b, dn, p, 1'b0);
  endtask

  task automatic guard(input logic [3:0] b, input logic dn, input logic p,
                       input logic f);
    chk(4'hF, b, dn, p, f);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        compare(e.tst, e.cyc,
                {bus.an, bus.bcd, bus.dp_n, bus.pending, bus.frame_done},
                {e.an, e.bcd, e.dp_n, e.pend, e.fd});
        $display("t%0d c%0d an=%b bcd=%h dp_n=%b pend=%b fd=%b", e.tst, e.cyc,
                 bus.an, bus.bcd, bus.dp_n, bus.pending, bus.frame_done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Idle after reset, load while off, commit in OFF, then one full frame.
    tst = 2;
    chk(4'hF, 4'h0, 1, 0, 0);
    bus.load = 1'b1; bus.data_in = 16'h1234; bus.dp_in = 4'b0000;
    chk(4'hF, 4'h0, 1, 1, 0);
    bus.load = 1'b0;
    chk(4'hF, 4'h0, 1, 0, 0);
    bus.en = 1'b1;
    drive(4'hE, 4'h4, 1, 0);
    guard(4'h3, 1, 0, 0); drive(4'hD, 4'h3, 1, 0);
    guard(4'h2, 1, 0, 0); drive(4'hB, 4'h2, 1, 0);
    guard(4'h1, 1, 0, 0); drive(4'h7, 4'h1, 1, 0);
    guard(4'h4, 1, 0, 1);

    // Load mid-frame: remaining digits keep old data until the wrap.
    tst = 3;
    drive(4'hE, 4'h4, 1, 0);
    guard(4'h3, 1, 0, 0);
    chk(4'hD, 4'h3, 1, 0, 0);
    bus.load = 1'b1; bus.data_in = 16'h5678; bus.dp_in = 4'b0010;
    chk(4'hD, 4'h3, 1, 1, 0);
    bus.load = 1'b0;
    chk(4'hD, 4'h3, 1, 1, 0); chk(4'hD, 4'h3, 1, 1, 0);
    guard(4'h2, 1, 1, 0); drive(4'hB, 4'h2, 1, 1);
    guard(4'h1, 1, 1, 0); drive(4'h7, 4'h1, 1, 1);
    guard(4'h8, 1, 0, 1);
    drive(4'hE, 4'h8, 1, 0);
    guard(4'h7, 0, 0, 0); drive(4'hD, 4'h7, 0, 0);
    guard(4'h6, 1, 0, 0); drive(4'hB, 4'h6, 1, 0);
    guard(4'h5, 1, 0, 0); drive(4'h7, 4'h5, 1, 0);
    guard(4'h8, 1, 0, 1);

    // Leading-zero suppression on 0070, then 0000 committed from OFF.
    tst = 4;
    bus.lz_en = 1'b1; bus.load = 1'b1; bus.data_in = 16'h0070; bus.dp_in = 4'b0000;
    chk(4'hE, 4'h8, 1, 1, 0);
    bus.load = 1'b0;
    repeat (3) chk(4'hE, 4'h8, 1, 1, 0);
    guard(4'h7, 0, 1, 0); drive(4'hD, 4'h7, 0, 1);
    guard(4'h6, 1, 1, 0); drive(4'hB, 4'h6, 1, 1);
    guard(4'h5, 1, 1, 0); drive(4'h7, 4'h5, 1, 1);
    guard(4'h0, 1, 0, 1);
    drive(4'hE, 4'h0, 1, 0);
    guard(4'h7, 1, 0, 0); drive(4'hD, 4'h7, 1, 0);
    guard(4'h0, 1, 0, 0); drive(4'hF, 4'h0, 1, 0);
    guard(4'h0, 1, 0, 0); drive(4'hF, 4'h0, 1, 0);
    guard(4'h0, 1, 0, 1);
    bus.en = 1'b0; bus.load = 1'b1; bus.data_in = 16'h0000;
    chk(4'hF, 4'h0, 1, 1, 0);
    bus.load = 1'b0; bus.en = 1'b1;
    drive(4'hE, 4'h0, 1, 0);
    for (int d = 1; d < ND; d++) begin
      guard(4'h0, 1, 0, 0); drive(4'hF, 4'h0, 1, 0);
    end
    guard(4'h0, 1, 0, 1);

    // Drop enable during digit 2, reload while off, restart at digit 0.
    tst = 5;
    bus.lz_en = 1'b0;
    drive(4'hE, 4'h0, 1, 0);
    guard(4'h0, 1, 0, 0); drive(4'hD, 4'h0, 1, 0);
    guard(4'h0, 1, 0, 0);
    chk(4'hB, 4'h0, 1, 0, 0);
    bus.en = 1'b0; bus.load = 1'b1; bus.data_in = 16'h1234; bus.dp_in = 4'b0001;
    chk(4'hF, 4'h0, 1, 1, 0);
    bus.en = 1'b1; bus.load = 1'b0;
    chk(4'hE, 4'h4, 0, 0, 0);

    // Load exactly on the wrap edge while another value is pending.
    tst = 6;
    chk(4'hE, 4'h4, 0, 0, 0);
    bus.load = 1'b1; bus.data_in = 16'h5678; bus.dp_in = 4'b0000;
    chk(4'hE, 4'h4, 0, 1, 0);
    bus.load = 1'b0;
    chk(4'hE, 4'h4, 0, 1, 0);
    guard(4'h3, 1, 1, 0); drive(4'hD, 4'h3, 1, 1);
    guard(4'h2, 1, 1, 0); drive(4'hB, 4'h2, 1, 1);
    guard(4'h1, 1, 1, 0); drive(4'h7, 4'h1, 1, 1);
    bus.load = 1'b1; bus.data_in = 16'h9A0F; bus.dp_in = 4'b1000;
    guard(4'h8, 1, 1, 1);
    bus.load = 1'b0;
    drive(4'hE, 4'h8, 1, 1);
    guard(4'h7, 1, 1, 0); drive(4'hD, 4'h7, 1, 1);
    guard(4'h6, 1, 1, 0); drive(4'hB, 4'h6, 1, 1);
    guard(4'h5, 1, 1, 0); drive(4'h7, 4'h5, 1, 1);
    guard(4'hF, 1, 0, 1);
    drive(4'hE, 4'hF, 1, 0);
    guard(4'h0, 1, 0, 0); drive(4'hD, 4'h0, 1, 0);
    guard(4'hA, 1, 0, 0);
    chk(4'hB, 4'hA, 1, 0, 0);
    bus.load = 1'b1; bus.data_in = 16'h4321;
    chk(4'hB, 4'hA, 1, 1, 0);
    bus.load = 1'b0;

    // Asynchronous reset mid-scan with data pending.
    tst = 1;
    rst_n = 1'b0;
    #1;
    compare(1, -1, {bus.an, bus.bcd, bus.dp_n, bus.pending, bus.frame_done},
            {4'hF, 4'h0, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    chk(4'hF, 4'h0, 1, 0, 0);
    chk(4'hF, 4'h0, 1, 0, 0);
    rst_n = 1'b1;
    chk(4'hE, 4'h0, 1, 0, 0);
    chk(4'hE, 4'h0, 1, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
